// File: rtl/div_iter_pkg.sv
// Shared types and handshake constants for the iterative divider.
package div_iter_pkg;
  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;
endpackage

// File: rtl/div_iter_if.sv
// EX <-> divider request/response bundle.
interface div_iter_if #(
  parameter int WIDTH = 32
);
  logic               signed_div;
  logic [WIDTH-1:0]   opdata1;
  logic [WIDTH-1:0]   opdata2;
  logic               start;
  logic               annul;
  logic [2*WIDTH-1:0] result;
  logic               ready;
  logic               busy;

  modport master (
    output signed_div, opdata1, opdata2, start, annul,
    input  result, ready, busy
  );

  modport slave (
    input  signed_div, opdata1, opdata2, start, annul,
    output result, ready, busy
  );
endinterface

// File: rtl/div_step.sv
// One restoring division step: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q
);
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // rem_in < divisor, so bit WIDTH of the trial difference is a reliable borrow flag
  assign shifted = {rem_in, bit_in};
  assign trial   = shifted - {1'b0, divisor};
  assign q       = ~trial[WIDTH];
  assign rem_out = q ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
endmodule

// File: rtl/div_iter.sv
// Multi-cycle signed/unsigned restoring divider; result = {remainder, quotient}.
module div_iter
  import div_iter_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input logic       clk,
  input logic       rst,
  div_iter_if.slave bus
);
  localparam int STEPS = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(STEPS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS);

  div_state_e         state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [WIDTH-1:0]   rem, rem_n, dvd, dvd_n, dvsr, dvsr_n;
  logic               neg_quo, neg_quo_n, neg_rem, neg_rem_n;
  logic [2*WIDTH-1:0] result, result_n;
  logic               ready, ready_n;
  logic [WIDTH-1:0]   rem_step, dvd_step, fin_quo, fin_rem;

  // dvd shifts left each step; freed LSBs collect the quotient bits
  for (genvar k = 0; k < BITS_PER_CYCLE; k++) begin : g_step
    logic [WIDTH-1:0] r_in, d_in, r_out, d_out;
    logic             q;
    if (k == 0) begin : g_first
      assign r_in = rem;
      assign d_in = dvd;
    end else begin : g_next
      assign r_in = g_step[k-1].r_out;
      assign d_in = g_step[k-1].d_out;
    end
    div_step #(.WIDTH(WIDTH)) u_step (
      .rem_in (r_in),
      .bit_in (d_in[WIDTH-1]),
      .divisor(dvsr),
      .rem_out(r_out),
      .q      (q)
    );
    assign d_out = {d_in[WIDTH-2:0], q};
  end

  assign rem_step = g_step[BITS_PER_CYCLE-1].r_out;
  assign dvd_step = g_step[BITS_PER_CYCLE-1].d_out;
  assign fin_quo  = neg_quo ? -dvd : dvd;
  assign fin_rem  = neg_rem ? -rem : rem;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    rem_n     = rem;
    dvd_n     = dvd;
    dvsr_n    = dvsr;
    neg_quo_n = neg_quo;
    neg_rem_n = neg_rem;
    result_n  = result;
    ready_n   = ready;
    unique case (state)
      DIV_FREE: begin
        if (bus.start == DIV_START && !bus.annul) begin
          if (bus.opdata2 == '0) begin
            state_n = DIV_BY_ZERO;
          end else begin
            state_n   = DIV_ON;
            cnt_n     = '0;
            rem_n     = '0;
            dvd_n     = (bus.signed_div && bus.opdata1[WIDTH-1]) ? -bus.opdata1 : bus.opdata1;
            dvsr_n    = (bus.signed_div && bus.opdata2[WIDTH-1]) ? -bus.opdata2 : bus.opdata2;
            neg_quo_n = bus.signed_div && (bus.opdata1[WIDTH-1] ^ bus.opdata2[WIDTH-1]);
            neg_rem_n = bus.signed_div && bus.opdata1[WIDTH-1];
          end
        end
      end
      DIV_BY_ZERO: begin
        state_n  = DIV_END;
        result_n = '0;
        ready_n  = DIV_RESULT_READY;
      end
      DIV_ON: begin
        if (bus.annul) begin
          state_n  = DIV_FREE;
          result_n = '0;
          ready_n  = DIV_RESULT_NOT_READY;
        end else if (cnt != CNT_LAST) begin
          rem_n = rem_step;
          dvd_n = dvd_step;
          cnt_n = cnt + CNT_W'(1);
        end else begin
          state_n  = DIV_END;
          result_n = {fin_rem, fin_quo};
          ready_n  = DIV_RESULT_READY;
        end
      end
      DIV_END: begin
        if (bus.start == DIV_STOP) begin
          state_n  = DIV_FREE;
          result_n = '0;
          ready_n  = DIV_RESULT_NOT_READY;
        end
      end
      default: state_n = DIV_FREE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= DIV_FREE;
      cnt     <= '0;
      rem     <= '0;
      dvd     <= '0;
      dvsr    <= '0;
      neg_quo <= 1'b0;
      neg_rem <= 1'b0;
      result  <= '0;
      ready   <= DIV_RESULT_NOT_READY;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      rem     <= rem_n;
      dvd     <= dvd_n;
      dvsr    <= dvsr_n;
      neg_quo <= neg_quo_n;
      neg_rem <= neg_rem_n;
      result  <= result_n;
      ready   <= ready_n;
    end
  end

  assign bus.result = result;
  assign bus.ready  = ready;
  assign bus.busy   = (state == DIV_BY_ZERO) || (state == DIV_ON);
endmodule

// File: tb/tb_div_iter.sv
// Directed and randomised checks of div_iter at 1, 2 and 4 bits per cycle, driven in lockstep.
module tb_div_iter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        signed_div = 1'b0;
  logic [31:0] op1 = '0;
  logic [31:0] op2 = '0;
  logic        start = 1'b0;
  logic        annul = 1'b0;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  div_iter_if #(.WIDTH(32)) if1 ();
  div_iter_if #(.WIDTH(32)) if2 ();
  div_iter_if #(.WIDTH(32)) if4 ();

  assign if1.signed_div = signed_div;
  assign if1.opdata1 = op1;
  assign if1.opdata2 = op2;
  assign if1.start = start;
  assign if1.annul = annul;
  assign if2.signed_div = signed_div;
  assign if2.opdata1 = op1;
  assign if2.opdata2 = op2;
  assign if2.start = start;
  assign if2.annul = annul;
  assign if4.signed_div = signed_div;
  assign if4.opdata1 = op1;
  assign if4.opdata2 = op2;
  assign if4.start = start;
  assign if4.annul = annul;

  div_iter #(.WIDTH(32), .BITS_PER_CYCLE(1)) u1 (.clk(clk), .rst(rst), .bus(if1));
  div_iter #(.WIDTH(32), .BITS_PER_CYCLE(2)) u2 (.clk(clk), .rst(rst), .bus(if2));
  div_iter #(.WIDTH(32), .BITS_PER_CYCLE(4)) u4 (.clk(clk), .rst(rst), .bus(if4));

  function automatic logic [63:0] ref_div(input logic sd, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (sd) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // Issue one operation on all three dividers; e* = edge (start edge = 1) at which ready was first seen.
  task automatic run_op(input logic sd, input logic [31:0] a, input logic [31:0] b, input bit scramble,
                        output logic [63:0] r1, output logic [63:0] r2, output logic [63:0] r4,
                        output int e1, output int e2, output int e4);
    signed_div = sd; op1 = a; op2 = b; start = 1'b1; annul = 1'b0;
    e1 = 0; e2 = 0; e4 = 0; r1 = 'x; r2 = 'x; r4 = 'x;
    for (int e = 1; e <= 80 && (e1 == 0 || e2 == 0 || e4 == 0); e++) begin
      @(posedge clk);
      @(negedge clk);
      if (scramble) begin op1 = ~a; op2 = b ^ 32'h5; signed_div = ~sd; end
      if (e1 == 0 && if1.ready) begin e1 = e; r1 = if1.result; end
      if (e2 == 0 && if2.ready) begin e2 = e; r2 = if2.result; end
      if (e4 == 0 && if4.ready) begin e4 = e; r4 = if4.result; end
    end
  endtask

  task automatic release_op();
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    tests++;
    if ({if1.result, if1.ready, if1.busy} !== 66'd0) begin
      fails++; $display("FAIL reset_outputs got %h want 0", {if1.result, if1.ready, if1.busy});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if ({if4.result, if4.ready, if4.busy} !== 66'd0) begin
      fails++; $display("FAIL reset_outputs_bpc4 got %h want 0", {if4.result, if4.ready, if4.busy});
    end
  endtask

  task automatic test_unsigned();
    logic [63:0] r1, r2, r4;
    int e1, e2, e4;
    run_op(1'b0, 32'd100, 32'd7, 1'b1, r1, r2, r4, e1, e2, e4);
    tests++;
    if (r1 !== {32'd2, 32'd14}) begin fails++; $display("FAIL udiv_100_7 got %h want %h", r1, {32'd2, 32'd14}); end
    tests++;
    if (e1 !== 34) begin fails++; $display("FAIL latency_bpc1 got %0d want 34", e1); end
    tests++;
    if (e2 !== 18 || r2 !== {32'd2, 32'd14}) begin fails++; $display("FAIL udiv_bpc2 got edge %0d res %h want 18 %h", e2, r2, {32'd2, 32'd14}); end
    // hold phase: result persists while start stays high
    repeat (3) @(negedge clk);
    tests++;
    if (if1.ready !== 1'b1 || if1.result !== {32'd2, 32'd14}) begin
      fails++; $display("FAIL end_hold got ready %b res %h want 1 %h", if1.ready, if1.result, {32'd2, 32'd14});
    end
    release_op();
    tests++;
    if (if1.ready !== 1'b0 || if1.result !== 64'd0) begin
      fails++; $display("FAIL end_release got ready %b res %h want 0 0", if1.ready, if1.result);
    end
  endtask

  task automatic test_signed();
    logic [63:0] r1, r2, r4;
    int e1, e2, e4;
    run_op(1'b1, -32'sd7, 32'd2, 1'b0, r1, r2, r4, e1, e2, e4);
    tests++;
    if (r1 !== {32'hFFFFFFFF, 32'hFFFFFFFD}) begin fails++; $display("FAIL sdiv_m7_2 got %h want ffffffff_fffffffd", r1); end
    release_op();
    run_op(1'b1, 32'd7, -32'sd2, 1'b0, r1, r2, r4, e1, e2, e4);
    tests++;
    if (r1 !== {32'd1, 32'hFFFFFFFD} || r4 !== {32'd1, 32'hFFFFFFFD}) begin
      fails++; $display("FAIL sdiv_7_m2 got %h / %h want 00000001_fffffffd", r1, r4);
    end
    release_op();
    run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b0, r1, r2, r4, e1, e2, e4);
    tests++;
    if (r1 !== {32'd0, 32'h80000000} || r2 !== {32'd0, 32'h80000000}) begin
      fails++; $display("FAIL sdiv_overflow got %h / %h want 00000000_80000000", r1, r2);
    end
    release_op();
  endtask

  task automatic test_by_zero();
    logic [63:0] r1, r2, r4;
    int e1, e2, e4;
    run_op(1'b0, 32'd5, 32'd0, 1'b0, r1, r2, r4, e1, e2, e4);
    tests++;
    if (e1 !== 2 || r1 !== 64'd0) begin fails++; $display("FAIL div_by_zero got edge %0d res %h want 2 0", e1, r1); end
    tests++;
    if (e4 !== 2 || r4 !== 64'd0) begin fails++; $display("FAIL div_by_zero_bpc4 got edge %0d res %h want 2 0", e4, r4); end
    release_op();
  endtask

  task automatic test_bpc4();
    logic [63:0] r1, r2, r4;
    int e1, e2, e4;
    run_op(1'b0, 32'hFFFFFFFF, 32'h10, 1'b0, r1, r2, r4, e1, e2, e4);
    tests++;
    if (e4 !== 10 || r4 !== {32'hF, 32'h0FFFFFFF}) begin
      fails++; $display("FAIL bpc4_ffffffff_10 got edge %0d res %h want 10 0000000f_0fffffff", e4, r4);
    end
    tests++;
    if (r1 !== {32'hF, 32'h0FFFFFFF}) begin fails++; $display("FAIL bpc1_ffffffff_10 got %h want 0000000f_0fffffff", r1); end
    release_op();
  endtask

  task automatic test_annul();
    logic [63:0] r1, r2, r4;
    int e1, e2, e4;
    bit seen = 1'b0;
    signed_div = 1'b0; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
    repeat (11) begin @(posedge clk); @(negedge clk); end
    annul = 1'b1; start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    annul = 1'b0;
    repeat (40) begin
      @(posedge clk);
      @(negedge clk);
      if (if1.ready) seen = 1'b1;
    end
    tests++;
    if (seen !== 1'b0 || if1.busy !== 1'b0 || if1.result !== 64'd0) begin
      fails++; $display("FAIL annul got ready_seen %b busy %b res %h want 0 0 0", seen, if1.busy, if1.result);
    end
    run_op(1'b0, 32'd9, 32'd3, 1'b0, r1, r2, r4, e1, e2, e4);
    tests++;
    if (r1 !== {32'd0, 32'd3} || e1 !== 34) begin fails++; $display("FAIL after_annul got edge %0d res %h want 34 %h", e1, r1, {32'd0, 32'd3}); end
    release_op();
  endtask

  task automatic test_reset_mid();
    signed_div = 1'b0; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
    repeat (12) begin @(posedge clk); @(negedge clk); end
    tests++;
    if (if1.busy !== 1'b1 || if4.result !== {32'd2, 32'd14}) begin
      fails++; $display("FAIL pre_reset got busy %b res4 %h want 1 %h", if1.busy, if4.result, {32'd2, 32'd14});
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if (if1.busy !== 1'b0 || if4.ready !== 1'b0 || if4.result !== 64'd0) begin
      fails++; $display("FAIL async_reset got busy %b ready4 %b res4 %h want 0 0 0", if1.busy, if4.ready, if4.result);
    end
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (if1.busy !== 1'b0 || if1.ready !== 1'b0) begin
      fails++; $display("FAIL post_reset got busy %b ready %b want 0 0", if1.busy, if1.ready);
    end
  endtask

  task automatic test_random();
    logic [63:0] r1, r2, r4, exp;
    int e1, e2, e4;
    logic        sd;
    logic [31:0] a, b;
    for (int i = 0; i < 12; i++) begin
      sd = 1'($urandom_range(0, 1));
      a  = (i % 3 == 0) ? 32'($urandom_range(0, 1000)) : $urandom;
      b  = (i % 4 == 1) ? 32'($urandom_range(1, 50)) : $urandom;
      if (b == 32'd0) b = 32'd3;
      if (sd && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd7;
      exp = ref_div(sd, a, b);
      run_op(sd, a, b, 1'b0, r1, r2, r4, e1, e2, e4);
      tests++;
      if (r1 !== exp || r2 !== exp || r4 !== exp) begin
        fails++; $display("FAIL random_%0d sd %b %h/%h got %h %h %h want %h", i, sd, a, b, r1, r2, r4, exp);
      end
      release_op();
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_by_zero();
    test_bpc4();
    test_annul();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
